// File: rtl/mac_sched_pkg.sv
// Shared types and width helpers for the MAC job scheduler.
package mac_sched_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StGrant,
        StRun,
        StDone
    } sched_state_e;

    function automatic int unsigned result_width(input int unsigned dw, input int unsigned k);
        return 2 * dw + $clog2(k);
    endfunction

    function automatic int unsigned beat_cnt_width(input int unsigned m, input int unsigned n,
                                                   input int unsigned k);
        return $clog2(m * n * k + 1);
    endfunction

endpackage

// File: rtl/mac_job_scheduler_if.sv
// Requester, engine and result-SRAM signals of the MAC job scheduler.
// master: scheduler side; slave: requesters, engine and SRAM side.
interface mac_job_scheduler_if #(
    parameter int unsigned M                        = 4,
    parameter int unsigned K                        = 4,
    parameter int unsigned N                        = 4,
    parameter int unsigned NUM_REQ                  = 2,
    parameter int unsigned DATA_WIDTH_INIT_MATRIX   = 32,
    parameter int unsigned DATA_WIDTH_RESULT_MATRIX =
        mac_sched_pkg::result_width(DATA_WIDTH_INIT_MATRIX, K)
);
    logic [NUM_REQ-1:0]                  req;
    logic [NUM_REQ-1:0]                  gnt;
    logic [NUM_REQ-1:0]                  done;
    logic                                err;
    logic                                eng_do_mac;
    logic                                eng_mult_done;
    logic [2*DATA_WIDTH_INIT_MATRIX-1:0] eng_product;
    logic                                eng_mac_done;
    logic                                c_we;
    logic [$clog2(M)-1:0]                c_row_addr;
    logic [$clog2(N)-1:0]                c_col_addr;
    logic [DATA_WIDTH_RESULT_MATRIX-1:0] c_data;

    modport master (
        input  req, eng_mult_done, eng_product, eng_mac_done,
        output gnt, done, err, eng_do_mac, c_we, c_row_addr, c_col_addr, c_data
    );

    modport slave (
        output req, eng_mult_done, eng_product, eng_mac_done,
        input  gnt, done, err, eng_do_mac, c_we, c_row_addr, c_col_addr, c_data
    );
endinterface

// File: rtl/mac_sched_rr_arbiter.sv
// Combinational round-robin pick: first set req bit at or after rr_ptr, cyclically.
module mac_sched_rr_arbiter #(
    parameter int unsigned NUM_REQ = 2
) (
    input  logic [NUM_REQ-1:0]         req,
    input  logic [$clog2(NUM_REQ)-1:0] rr_ptr,
    output logic [NUM_REQ-1:0]         grant,
    output logic [$clog2(NUM_REQ)-1:0] owner
);
    localparam int unsigned IW = $clog2(NUM_REQ);

    logic [IW-1:0] idx;
    logic          found;

    always_comb begin
        grant = '0;
        owner = '0;
        found = 1'b0;
        idx   = '0;
        for (int unsigned off = 0; off < NUM_REQ; off++) begin
            idx = IW'((32'(rr_ptr) + off) % NUM_REQ);
            if (!found && req[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                owner      = idx;
            end
        end
    end
endmodule

// File: rtl/mac_job_scheduler.sv
// Round-robin job scheduler and C-element accumulator for the mac_stop_mult engine.
// Define MAC_SCHED_TIMEOUT_EN to add a RUN-state watchdog of TIMEOUT_CYCLES.
module mac_job_scheduler
    import mac_sched_pkg::*;
#(
    parameter int unsigned M                        = 4,
    parameter int unsigned K                        = 4,
    parameter int unsigned N                        = 4,
    parameter int unsigned NUM_REQ                  = 2,
    parameter int unsigned DATA_WIDTH_INIT_MATRIX   = 32,
    parameter int unsigned DATA_WIDTH_RESULT_MATRIX = result_width(DATA_WIDTH_INIT_MATRIX, K),
    parameter int unsigned TIMEOUT_CYCLES           = 64
) (
    input logic                  clk,
    input logic                  resetn,
    mac_job_scheduler_if.master  bus
);
    localparam int unsigned IW   = $clog2(NUM_REQ);
    localparam int unsigned RowW = $clog2(M);
    localparam int unsigned ColW = $clog2(N);
    localparam int unsigned KW   = $clog2(K);
    localparam int unsigned BW   = beat_cnt_width(M, N, K);
    localparam int unsigned RW   = DATA_WIDTH_RESULT_MATRIX;

    localparam logic [KW-1:0]   KLast      = KW'(K - 1);
    localparam logic [ColW-1:0] NLast      = ColW'(N - 1);
    localparam logic [RowW-1:0] MLast      = RowW'(M - 1);
    localparam logic [IW-1:0]   ReqLast    = IW'(NUM_REQ - 1);
    localparam logic [BW-1:0]   BeatsTotal = BW'(M * N * K);
    localparam logic [BW-1:0]   BeatMax    = {BW{1'b1}};

    sched_state_e        state_q, state_d;
    logic [IW-1:0]       owner_q, owner_d, rr_ptr_q, rr_ptr_d;
    logic [RW-1:0]       acc_q, acc_d;
    logic [KW-1:0]       k_q, k_d;
    logic [RowW-1:0]     i_q, i_d;
    logic [ColW-1:0]     j_q, j_d;
    logic [BW-1:0]       beat_q, beat_d;
    logic [NUM_REQ-1:0]  gnt_q, gnt_d, done_q, done_d;
    logic                err_q, err_d, do_mac_q, do_mac_d, c_we_q, c_we_d;
    logic [RowW-1:0]     c_row_q, c_row_d;
    logic [ColW-1:0]     c_col_q, c_col_d;
    logic [RW-1:0]       c_data_q, c_data_d;
    logic [NUM_REQ-1:0]  arb_grant;
    logic [IW-1:0]       arb_owner;
    logic [RW-1:0]       prod_ext;

`ifdef MAC_SCHED_TIMEOUT_EN
    localparam int unsigned WW         = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WW-1:0] TimeoutVal = WW'(TIMEOUT_CYCLES);
    logic [WW-1:0] wd_q, wd_d;
`endif

    assign prod_ext = RW'(bus.eng_product);

    mac_sched_rr_arbiter #(
        .NUM_REQ(NUM_REQ)
    ) u_arb (
        .req   (bus.req),
        .rr_ptr(rr_ptr_q),
        .grant (arb_grant),
        .owner (arb_owner)
    );

    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        rr_ptr_d = rr_ptr_q;
        acc_d    = acc_q;
        k_d      = k_q;
        i_d      = i_q;
        j_d      = j_q;
        beat_d   = beat_q;
        gnt_d    = '0;
        done_d   = '0;
        err_d    = 1'b0;
        do_mac_d = do_mac_q;
        c_we_d   = 1'b0;
        c_row_d  = c_row_q;
        c_col_d  = c_col_q;
        c_data_d = c_data_q;
`ifdef MAC_SCHED_TIMEOUT_EN
        wd_d     = wd_q;
`endif
        case (state_q)
            StIdle: begin
                if (|bus.req) begin
                    owner_d = arb_owner;
                    gnt_d   = arb_grant;
                    state_d = StGrant;
                end
            end
            StGrant: begin
                acc_d    = '0;
                k_d      = '0;
                i_d      = '0;
                j_d      = '0;
                beat_d   = '0;
                do_mac_d = 1'b1;
                state_d  = StRun;
`ifdef MAC_SCHED_TIMEOUT_EN
                wd_d     = '0;
`endif
            end
            StRun: begin
                if (bus.eng_mult_done) begin
                    beat_d = (beat_q == BeatMax) ? beat_q : beat_q + 1'b1;
                    if (k_q == KLast) begin
                        c_we_d   = 1'b1;
                        c_data_d = acc_q + prod_ext;
                        c_row_d  = i_q;
                        c_col_d  = j_q;
                        acc_d    = '0;
                        k_d      = '0;
                        if (j_q == NLast) begin
                            j_d = '0;
                            i_d = (i_q == MLast) ? '0 : i_q + 1'b1;
                        end else begin
                            j_d = j_q + 1'b1;
                        end
                    end else begin
                        acc_d = acc_q + prod_ext;
                        k_d   = k_q + 1'b1;
                    end
                end
`ifdef MAC_SCHED_TIMEOUT_EN
                wd_d = bus.eng_mult_done ? '0 : wd_q + 1'b1;
`endif
                // err uses post-beat counts so a final beat coincident with mac_done counts.
                if (bus.eng_mac_done) begin
                    state_d         = StDone;
                    do_mac_d        = 1'b0;
                    done_d[owner_q] = 1'b1;
                    err_d           = (beat_d != BeatsTotal) || (k_d != '0);
                end
`ifdef MAC_SCHED_TIMEOUT_EN
                else if (wd_d == TimeoutVal) begin
                    state_d         = StDone;
                    do_mac_d        = 1'b0;
                    done_d[owner_q] = 1'b1;
                    err_d           = 1'b1;
                end
`endif
            end
            StDone: begin
                rr_ptr_d = (owner_q == ReqLast) ? '0 : owner_q + 1'b1;
                state_d  = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q  <= StIdle;
            owner_q  <= '0;
            rr_ptr_q <= '0;
            acc_q    <= '0;
            k_q      <= '0;
            i_q      <= '0;
            j_q      <= '0;
            beat_q   <= '0;
            gnt_q    <= '0;
            done_q   <= '0;
            err_q    <= 1'b0;
            do_mac_q <= 1'b0;
            c_we_q   <= 1'b0;
            c_row_q  <= '0;
            c_col_q  <= '0;
            c_data_q <= '0;
`ifdef MAC_SCHED_TIMEOUT_EN
            wd_q     <= '0;
`endif
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            rr_ptr_q <= rr_ptr_d;
            acc_q    <= acc_d;
            k_q      <= k_d;
            i_q      <= i_d;
            j_q      <= j_d;
            beat_q   <= beat_d;
            gnt_q    <= gnt_d;
            done_q   <= done_d;
            err_q    <= err_d;
            do_mac_q <= do_mac_d;
            c_we_q   <= c_we_d;
            c_row_q  <= c_row_d;
            c_col_q  <= c_col_d;
            c_data_q <= c_data_d;
`ifdef MAC_SCHED_TIMEOUT_EN
            wd_q     <= wd_d;
`endif
        end
    end

    assign bus.gnt        = gnt_q;
    assign bus.done       = done_q;
    assign bus.err        = err_q;
    assign bus.eng_do_mac = do_mac_q;
    assign bus.c_we       = c_we_q;
    assign bus.c_row_addr = c_row_q;
    assign bus.c_col_addr = c_col_q;
    assign bus.c_data     = c_data_q;
endmodule

// File: tb/tb_mac_job_scheduler.sv
// Scoreboard bench for mac_job_scheduler: engine model drives beats, C writes checked in order.
module tb_mac_job_scheduler;
    localparam int unsigned M   = 4;
    localparam int unsigned K   = 4;
    localparam int unsigned N   = 4;
    localparam int unsigned NR  = 2;
    localparam int unsigned DW  = 32;
    localparam int unsigned RW  = 2 * DW + $clog2(K);
    localparam int unsigned TMO = 64;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    mac_job_scheduler_if #(
        .M(M), .K(K), .N(N), .NUM_REQ(NR),
        .DATA_WIDTH_INIT_MATRIX(DW), .DATA_WIDTH_RESULT_MATRIX(RW)
    ) bus ();

    mac_job_scheduler #(
        .M(M), .K(K), .N(N), .NUM_REQ(NR),
        .DATA_WIDTH_INIT_MATRIX(DW), .DATA_WIDTH_RESULT_MATRIX(RW), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk   (clk),
        .resetn(resetn),
        .bus   (bus)
    );

    typedef struct {
        int            row;
        int            col;
        logic [RW-1:0] data;
    } wr_t;

    wr_t exp_q[$];
    int  n_vec = 0;
    int  n_miss = 0;
    int  cyc = 0;
    int  wr_cnt = 0;
    int  done_cnt = 0;
    int  done_cyc = 0;
    int  we_cyc = 0;
    int  gnt_cyc = 0;
    int  beat_cyc = 0;
    logic [NR-1:0] done_vec = '0;
    logic          err_seen = 1'b0;
    logic [RW-1:0] c_cap[M][N];

    int a_m[M][K] = '{'{6, 2, 5, 2}, '{6, 2, 6, 1}, '{2, 4, 5, 2}, '{7, 2, 5, 1}};
    int b_m[K][N] = '{'{1, 1, 4, 4}, '{1, 7, 2, 1}, '{3, 2, 1, 1}, '{2, 1, 6, 6}};

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [RW-1:0] model_c(input int i, input int j);
        logic [RW-1:0] s;
        s = '0;
        for (int k = 0; k < K; k++) s = s + RW'(a_m[i][k] * b_m[k][j]);
        return s;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        wr_t e;
        if (bus.c_we) begin
            wr_cnt++;
            we_cyc = cyc;
            c_cap[bus.c_row_addr][bus.c_col_addr] = bus.c_data;
            if (exp_q.size() == 0) begin
                check("c_we_unexpected", 1, 0);
            end else begin
                e = exp_q.pop_front();
                check("c_row", 128'(bus.c_row_addr), 128'(e.row));
                check("c_col", 128'(bus.c_col_addr), 128'(e.col));
                check("c_data", 128'(bus.c_data), 128'(e.data));
            end
        end
        if (|bus.done) begin
            done_cnt++;
            done_cyc = cyc;
            done_vec = bus.done;
            err_seen = bus.err;
        end
    end

    task automatic check_zero_outputs(input string tag);
        check({tag, "_gnt"}, 128'(bus.gnt), 0);
        check({tag, "_done"}, 128'(bus.done), 0);
        check({tag, "_err"}, 128'(bus.err), 0);
        check({tag, "_do_mac"}, 128'(bus.eng_do_mac), 0);
        check({tag, "_c_we"}, 128'(bus.c_we), 0);
        check({tag, "_row"}, 128'(bus.c_row_addr), 0);
        check({tag, "_col"}, 128'(bus.c_col_addr), 0);
        check({tag, "_data"}, 128'(bus.c_data), 0);
    endtask

    // mode 0: mac_done one cycle after the last beat; 1: with the last beat; 2: never.
    task automatic drive_beats(input int nbeats, input int mode);
        logic [RW-1:0]     sum;
        logic [2*DW-1:0]   prod;
        int                i, j, k;
        sum = '0;
        for (int idx = 0; idx < nbeats; idx++) begin
            i    = idx / (N * K);
            j    = (idx / K) % N;
            k    = idx % K;
            prod = (2*DW)'(a_m[i][k] * b_m[k][j]);
            bus.eng_mult_done = 1'b0;
            repeat ($urandom_range(0, 1)) begin @(posedge clk); #1; end
            bus.eng_mult_done = 1'b1;
            bus.eng_product   = prod;
            bus.eng_mac_done  = (mode == 1) && (idx == nbeats - 1);
            sum = sum + RW'(prod);
            if (k == K - 1) begin
                exp_q.push_back('{row: i, col: j, data: sum});
                sum = '0;
            end
            @(posedge clk); #1;
            beat_cyc = cyc;
        end
        bus.eng_mult_done = 1'b0;
        bus.eng_mac_done  = 1'b0;
        if (mode == 0) begin
            bus.eng_mac_done = 1'b1;
            @(posedge clk); #1;
            bus.eng_mac_done = 1'b0;
        end
    endtask

    task automatic run_job(input logic [NR-1:0] req_set, input logic [NR-1:0] exp_gnt,
                           input bit drop, input int nbeats, input int mode,
                           input bit exp_err, input bit chk_lat);
        int base_wr, base_done, req_cyc, t;
        base_wr   = wr_cnt;
        base_done = done_cnt;
        bus.req   = bus.req | req_set;
        req_cyc   = cyc;
        t = 0;
        while (!(|bus.gnt) && t < 50) begin @(negedge clk); #1; t++; end
        if (!(|bus.gnt)) begin
            check("gnt_timeout", 0, 1);
            return;
        end
        check("gnt_onehot", 128'(bus.gnt), 128'(exp_gnt));
        if (chk_lat) check("gnt_latency", 128'(cyc - req_cyc), 1);
        gnt_cyc = cyc;
        if (drop) bus.req = bus.req & ~bus.gnt;
        @(posedge clk); #1;
        check("do_mac_on", 128'(bus.eng_do_mac), 1);
        drive_beats(nbeats, mode);
        if (mode == 2) return;
        t = 0;
        while (done_cnt == base_done && t < 200) begin @(negedge clk); #1; t++; end
        if (done_cnt == base_done) begin
            check("done_timeout", 0, 1);
            return;
        end
        check("done_owner", 128'(done_vec), 128'(exp_gnt));
        check("done_err", 128'(err_seen), 128'(exp_err));
        check("wr_count", 128'(wr_cnt - base_wr), 128'(nbeats / K));
        check("do_mac_off", 128'(bus.eng_do_mac), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        int saved_done;
        bus.req = '0;
        bus.eng_mult_done = 1'b0;
        bus.eng_product = '0;
        bus.eng_mac_done = 1'b0;
        resetn = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_zero_outputs("rst");
        resetn = 1'b1;
        @(posedge clk); #1;

        // Full job from requester 0 with the reference matrices.
        run_job(2'b01, 2'b01, 1'b1, M * N * K, 0, 1'b0, 1'b1);
        check("c00", 128'(c_cap[0][0]), 27);
        check("c01", 128'(c_cap[0][1]), 32);
        check("c33", 128'(c_cap[3][3]), 128'(model_c(3, 3)));
        check("sb_empty_1", 128'(exp_q.size()), 0);

        // Last beat coincides with eng_mac_done.
        @(posedge clk); #1;
        run_job(2'b01, 2'b01, 1'b1, M * N * K, 1, 1'b0, 1'b1);
        check("we_with_done", 128'(done_cyc - we_cyc), 0);

        // Early eng_mac_done after 60 beats.
        @(posedge clk); #1;
        run_job(2'b10, 2'b10, 1'b1, 60, 0, 1'b1, 1'b1);
        check("sb_empty_2", 128'(exp_q.size()), 0);

        // Both requesters held from reset: grants alternate 0,1,0,1.
        resetn = 1'b0;
        @(posedge clk); #1;
        resetn = 1'b1;
        bus.req = 2'b11;
        for (int n = 0; n < 4; n++) begin
            run_job(2'b00, (n % 2 == 0) ? 2'b01 : 2'b10, 1'b0, K, 0, 1'b1, 1'b0);
            if (n > 0) check("regrant_gap", 128'(gnt_cyc - saved_done), 2);
            saved_done = done_cyc;
            if (n < 3) begin @(posedge clk); #1; end
        end
        bus.req = '0;

        // Reset after 20 beats drops the job silently.
        @(posedge clk); #1;
        @(posedge clk); #1;
        run_job(2'b01, 2'b01, 1'b1, 20, 2, 1'b0, 1'b1);
        saved_done = done_cnt;
        resetn = 1'b0;
        @(posedge clk); #1;
        resetn = 1'b1;
        check_zero_outputs("midrst");
        exp_q.delete();
        repeat (5) @(posedge clk);
        #1;
        check("no_done_after_rst", 128'(done_cnt), 128'(saved_done));
        for (int i = 0; i < M; i++)
            for (int j = 0; j < N; j++) c_cap[i][j] = '0;
        run_job(2'b10, 2'b10, 1'b1, M * N * K, 0, 1'b0, 1'b1);
        check("post_rst_c00", 128'(c_cap[0][0]), 27);
        check("post_rst_c33", 128'(c_cap[3][3]), 128'(model_c(3, 3)));

`ifdef MAC_SCHED_TIMEOUT_EN
        // Engine stalls after 10 beats; watchdog ends the job.
        @(posedge clk); #1;
        begin
            int base_wr, t;
            base_wr    = wr_cnt;
            saved_done = done_cnt;
            run_job(2'b01, 2'b01, 1'b1, 10, 2, 1'b1, 1'b1);
            t = 0;
            while (done_cnt == saved_done && t < 200) begin @(negedge clk); #1; t++; end
            check("tmo_done_seen", 128'(done_cnt - saved_done), 1);
            check("tmo_err", 128'(err_seen), 1);
            check("tmo_delay", 128'(done_cyc - beat_cyc), 128'(TMO));
            check("tmo_wr_count", 128'(wr_cnt - base_wr), 2);
            check("tmo_do_mac", 128'(bus.eng_do_mac), 0);
            repeat (3) @(posedge clk);
            #1;
            check("tmo_do_mac_later", 128'(bus.eng_do_mac), 0);
        end
`endif

        repeat (3) @(posedge clk);
        #1;
        check("sb_empty_end", 128'(exp_q.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
